// File: rtl/pc_sequencer_pkg.sv
// Shared constants and action encoding for the program-address sequencer.
// Optional interrupt entry is compiled in with the PC_IRQ_EN macro.
package pc_sequencer_pkg;

  localparam int unsigned PcAddrW      = 8;
  localparam int unsigned PcStackDepth = 4;
  localparam int unsigned PcIrqVec     = 'h10;

  // Winning request for a cycle, highest priority first.
  typedef enum logic [2:0] {
    ActHold,
    ActIrq,
    ActRet,
    ActCall,
    ActBranch,
    ActInc
  } act_e;

endpackage

// File: rtl/pc_return_stack.sv
// Register-array LIFO holding return addresses; only the fill level is reset.
module pc_return_stack #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [Width-1:0]             data_i,
  output logic [Width-1:0]             top_o,
  output logic [$clog2(Depth+1)-1:0]   level_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned LvlW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [LvlW-1:0]  level_q;

  assign level_o = level_q;
  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (LvlW'(i + 1) == level_q) top_o = mem_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < Depth; i++) begin
      if (push_i && !full_o && (LvlW'(i) == level_q)) mem_q[i] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else if (push_i && !full_o) begin
      level_q <= level_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: increment/branch/call/return with a return stack and sticky
// stack-error flags. Define PC_IRQ_EN to add the irq/iret/irq_ack interrupt entry.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W      = PcAddrW,
  parameter int unsigned       STACK_DEPTH = PcStackDepth,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
`ifdef PC_IRQ_EN
  ,
  parameter logic [ADDR_W-1:0] IRQ_VEC     = ADDR_W'(PcIrqVec)
`endif
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               branch,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  target,
  input  logic                               err_clr,
`ifdef PC_IRQ_EN
  input  logic                               irq,
  input  logic                               iret,
  output logic                               irq_ack,
`endif
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_level,
  output logic                               stk_full,
  output logic                               stk_empty,
  output logic                               stk_ovf,
  output logic                               stk_unf
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, push_data, top;
  logic              push, pop, full, empty;
  logic              ovf_q, unf_q, ovf_set, unf_set;
  logic              irq_entry, ret_req;
  act_e              act;

  assign pc_inc = pc_q + 1'b1;

`ifdef PC_IRQ_EN
  logic busy_q, busy_d, ack_q;
  assign irq_entry = irq & ~busy_q;
  assign ret_req   = ret | iret;
  assign irq_ack   = ack_q;
`else
  assign irq_entry = 1'b0;
  assign ret_req   = ret;
`endif

  always_comb begin
    if (stall)          act = ActHold;
    else if (irq_entry) act = ActIrq;
    else if (ret_req)   act = ActRet;
    else if (call)      act = ActCall;
    else if (branch)    act = ActBranch;
    else                act = ActInc;
  end

  always_comb begin
    pc_d      = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    unique case (act)
      ActHold: pc_d = pc_q;
`ifdef PC_IRQ_EN
      // Interrupt saves the address that was not yet executed.
      ActIrq: begin
        push      = ~full;
        ovf_set   = full;
        push_data = pc_q;
        pc_d      = IRQ_VEC;
      end
`endif
      ActRet: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          pop  = 1'b1;
          pc_d = top;
        end
      end
      ActCall: begin
        push    = ~full;
        ovf_set = full;
        pc_d    = target;
      end
      ActBranch: pc_d = target;
      default: ;
    endcase
  end

`ifdef PC_IRQ_EN
  always_comb begin
    busy_d = busy_q;
    if (act == ActIrq)              busy_d = 1'b1;
    else if (act == ActRet && iret) busy_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_VEC;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
`ifdef PC_IRQ_EN
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
`endif
    end else begin
      pc_q   <= pc_d;
      // A set in the same cycle as err_clr leaves the flag high.
      ovf_q  <= (ovf_q & ~err_clr) | ovf_set;
      unf_q  <= (unf_q & ~err_clr) | unf_set;
`ifdef PC_IRQ_EN
      busy_q <= busy_d;
      ack_q  <= (act == ActIrq);
`endif
    end
  end

  pc_return_stack #(
    .Width (ADDR_W),
    .Depth (STACK_DEPTH)
  ) u_stack (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_data),
    .top_o   (top),
    .level_o (sp_level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign pc_out    = pc_q;
  assign stk_full  = full;
  assign stk_empty = empty;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule
